sram_controller: RTL and testbench
==================================

# sram_controller

Multi-cycle controller between the MEM stage and the off-chip 16-bit SRAM. It turns each 32-bit word read or write from the pipeline into two sequenced half-word SRAM accesses and owns the SRAM bus pins. It raises `ready` only when the word transfer is complete; the pipeline derives its freeze from `~ready`. It sits under the MEM stage logic, replacing direct array access.

## Interface
- `WAIT_CYCLES`, default 1: cycles per half-word phase; legal values are 1 to 15.
- `ADDR_BASE`, default 1024: byte address that maps to SRAM word 0.

Ports:
- `clk` in 1: the single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `rd_en` in 1: word read request; held until `ready` is seen.
- `wr_en` in 1: word write request; held until `ready` is seen.
- `address` in 32: byte address, word-aligned.
- `write_data` in 32: word to be written.
- `read_data` out 32: word read back; registered.
- `ready` out 1: high when no access is pending, or when the access completes this cycle.
- `addr_err` out 1: one-cycle pulse on an out-of-range access. Present only with the Configuration macro; otherwise tied 0.
- `SRAM_DQ` inout 16: SRAM data bus.
- `SRAM_ADDR` out 18: SRAM half-word address.
- `SRAM_WE_N` out 1: SRAM write strobe, active-low.
- `SRAM_UB_N`, `SRAM_LB_N`, `SRAM_CE_N`, `SRAM_OE_N` out 1 each: tied 0.

## Operation
- Address translation:
  - `off = address - ADDR_BASE`, computed 32-bit.
  - `word = off[18:2]`, 17 bits.
  - `SRAM_ADDR = {word, half}`, where `half` is 0 for the low phase and 1 for the high phase.
  - The low half-word is stored at the even address.
- FSM states: IDLE, LOW, HIGH, DONE.
  - IDLE: if `wr_en` or `rd_en` is high, latch `address`, `write_data` and the operation type, then go to LOW. When both are high, the write wins.
  - LOW: stay `WAIT_CYCLES` cycles using a 4-bit phase counter that reloads on entry. Then go to HIGH.
  - HIGH: stay `WAIT_CYCLES` cycles, then go to DONE.
  - DONE: one cycle, then return to IDLE unconditionally.
- Write phases:
  - `SRAM_WE_N` = 0 for every cycle of the phase.
  - `SRAM_DQ` is driven with `wdata[15:0]` during LOW and `wdata[31:16]` during HIGH.
- Read phases:
  - `SRAM_WE_N` = 1 and `SRAM_DQ` is high-Z.
  - `SRAM_DQ` is sampled on the last cycle of LOW into `read_data[15:0]`, and on the last cycle of HIGH into `read_data[31:16]`.
- Outside LOW and HIGH: `SRAM_DQ` is high-Z, `SRAM_WE_N` = 1, and `SRAM_ADDR` holds its last value.
- `ready` is combinational: `(IDLE && !rd_en && !wr_en) || DONE`.
- `read_data` holds its value until the next read completes; writes do not change it.

## Timing
- Reset values: state IDLE, `read_data` 0, `SRAM_ADDR` 0, `SRAM_WE_N` 1, `SRAM_DQ` high-Z, `addr_err` 0. `ready` is 1 while requests are low.
- Latency: the request is seen in IDLE in cycle 0. LOW covers cycles 1..W, HIGH covers cycles W+1..2W, and DONE is cycle 2W+1 with `ready` = 1.
  - The freeze therefore lasts 2W+1 cycles; with W=1, `ready` rises in cycle 3.
- `read_data` is valid in the DONE cycle.
- A request present in the cycle after DONE is treated as a new access. The pipeline advances on DONE, so there are no duplicate transfers.
- Request inputs are ignored outside IDLE. Dropping `rd_en`/`wr_en` mid-access does not abort it.
- Reset asserted mid-access: the FSM returns to IDLE immediately and the SRAM bus is released. The half-word already written is not rolled back.
- Back-to-back accesses: after DONE there is one IDLE cycle, then LOW again.

## Configuration
- With `SRAM_ADDR_CHECK_EN` defined:
  - An access is out of range if `address < ADDR_BASE` or `off[31:19] != 0`.
  - An out-of-range access goes IDLE→DONE directly with no SRAM cycle. `SRAM_WE_N` stays 1.
  - A read returns `read_data` = 0.
  - `addr_err` = 1 during that DONE cycle.
- Without `SRAM_ADDR_CHECK_EN`:
  - `off` is truncated to `off[18:2]` with no check.
  - `addr_err` is constant 0.

## Test plan
- Reset: `rst`=0 mid-write at W=1 → next cycle state IDLE, `SRAM_WE_N`=1, `SRAM_DQ` high-Z, `read_data`=0, `ready`=1.
- Write then read, W=1:
  - Write `address`=1024, `write_data`=0xDEADBEEF → `SRAM_ADDR`=0 with DQ 0xBEEF in cycle 1, `SRAM_ADDR`=1 with DQ 0xDEAD in cycle 2, `ready`=1 in cycle 3.
  - Read of the same address → `read_data`=0xDEADBEEF in cycle 3.
- Wait states, W=3: read of `address`=1032 → `SRAM_ADDR` 4 during cycles 1–3, 5 during cycles 4–6, `ready` only in cycle 7.
- Simultaneous requests: `rd_en`=`wr_en`=1 with `write_data`=0x12345678 → a write is performed (`SRAM_WE_N`=0 in both phases) and `read_data` is unchanged.
- Back-to-back: two reads held continuously (1024, then 1028) → `ready` pulses in cycles 3 and 7; `SRAM_ADDR` sequence 0,1,2,3.
- With `SRAM_ADDR_CHECK_EN`: read of `address`=16 → `ready`=1 and `addr_err`=1 in cycle 1, `read_data`=0, `SRAM_WE_N` never low.

Source files
------------

// File: rtl/sram_controller.sv
// Word-to-half-word SRAM controller: each 32-bit pipeline access becomes a low and a high 16-bit SRAM phase.
// Define SRAM_ADDR_CHECK_EN to reject out-of-range addresses with a one-cycle addr_err pulse.
module sram_controller #(
    parameter int          WAIT_CYCLES = 1,
    parameter logic [31:0] ADDR_BASE   = 32'd1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rd_en,
    input  logic        wr_en,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready,
    output logic        addr_err,
    inout  wire  [15:0] SRAM_DQ,
    output logic [17:0] SRAM_ADDR,
    output logic        SRAM_WE_N,
    output logic        SRAM_UB_N,
    output logic        SRAM_LB_N,
    output logic        SRAM_CE_N,
    output logic        SRAM_OE_N
);

    typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} StateType;

    localparam logic [3:0] RELOAD = 4'(WAIT_CYCLES - 1);

    StateType    r_state;
    StateType    w_nextState;
    logic [3:0]  r_cnt;
    logic [16:0] r_word;
    logic [31:0] r_wdata;
    logic        r_isWrite;
    logic [31:0] r_readData;
    logic [17:0] r_sramAddr;

    logic [31:0] w_off;
    logic [16:0] w_word;
    logic        w_req;
    logic        w_last;
    logic        w_outOfRange;
    logic        w_active;
    logic [15:0] w_dqOut;
    logic        w_unused;

    assign w_off    = address - ADDR_BASE;
    assign w_word   = w_off[18:2];
    assign w_req    = rd_en | wr_en;
    assign w_last   = (r_cnt == 4'd0);
    assign w_unused = ^{w_off[31:19], w_off[1:0]};

`ifdef SRAM_ADDR_CHECK_EN
    logic r_addrErr;

    assign w_outOfRange = (address < ADDR_BASE) || (w_off[31:19] != 13'd0);

    // Pulse lines up with the DONE cycle that an out-of-range request jumps to.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_addrErr <= 1'b0;
        end else begin
            r_addrErr <= (r_state == IDLE) && w_req && w_outOfRange;
        end
    end

    assign addr_err = r_addrErr;
`else
    assign w_outOfRange = 1'b0;
    assign addr_err     = 1'b0;
`endif

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: if (w_req) w_nextState = w_outOfRange ? DONE : LOW;
            LOW:  if (w_last) w_nextState = HIGH;
            HIGH: if (w_last) w_nextState = DONE;
            DONE: w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // The SRAM address is registered so it is stable for a whole phase and holds between accesses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_cnt      <= 4'd0;
            r_word     <= 17'd0;
            r_wdata    <= 32'd0;
            r_isWrite  <= 1'b0;
            r_readData <= 32'd0;
            r_sramAddr <= 18'd0;
        end else begin
            r_state <= w_nextState;
            case (r_state)
                IDLE: begin
                    if (w_req) begin
                        r_isWrite <= wr_en;
                        r_wdata   <= write_data;
                        r_word    <= w_word;
                        r_cnt     <= RELOAD;
                        if (w_outOfRange) begin
                            if (!wr_en) r_readData <= 32'd0;
                        end else begin
                            r_sramAddr <= {w_word, 1'b0};
                        end
                    end
                end
                LOW: begin
                    if (w_last) begin
                        r_cnt      <= RELOAD;
                        r_sramAddr <= {r_word, 1'b1};
                        if (!r_isWrite) r_readData[15:0] <= SRAM_DQ;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                HIGH: begin
                    if (w_last) begin
                        if (!r_isWrite) r_readData[31:16] <= SRAM_DQ;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign w_active  = (r_state == LOW) || (r_state == HIGH);
    assign w_dqOut   = (r_state == HIGH) ? r_wdata[31:16] : r_wdata[15:0];
    assign SRAM_WE_N = !(w_active && r_isWrite);
    assign SRAM_DQ   = SRAM_WE_N ? 16'bz : w_dqOut;
    assign SRAM_ADDR = r_sramAddr;
    assign read_data = r_readData;
    assign ready     = ((r_state == IDLE) && !w_req) || (r_state == DONE);

    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;
    assign SRAM_CE_N = 1'b0;
    assign SRAM_OE_N = 1'b0;

endmodule

// File: tb/tb_sram_controller.sv
// Bench for sram_controller: two instances (W=1, W=3), each with a behavioural 16-bit SRAM,
// checked against a word-level reference memory. Honours SRAM_ADDR_CHECK_EN like the design.
module tb_sram_controller;

    localparam logic [31:0] BASE = 32'd1024;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rdEn = 1'b0;
    logic        wrEn = 1'b0;
    logic [31:0] address = BASE;
    logic [31:0] writeData = 32'd0;
    int          sel = 0;
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    logic        rd0, wr0, rd1, wr1;
    logic [31:0] readData0, readData1;
    logic        ready0, ready1, addrErr0, addrErr1;
    wire  [15:0] dq0, dq1;
    logic [17:0] sramAddr0, sramAddr1;
    logic        weN0, weN1;
    logic        ub0, lb0, ce0, oe0, ub1, lb1, ce1, oe1;

    assign rd0 = rdEn && (sel == 0);
    assign wr0 = wrEn && (sel == 0);
    assign rd1 = rdEn && (sel == 1);
    assign wr1 = wrEn && (sel == 1);

    sram_controller #(.WAIT_CYCLES(1), .ADDR_BASE(BASE)) dut0 (
        .clk(clk), .rst(rst), .rd_en(rd0), .wr_en(wr0), .address(address), .write_data(writeData),
        .read_data(readData0), .ready(ready0), .addr_err(addrErr0), .SRAM_DQ(dq0), .SRAM_ADDR(sramAddr0),
        .SRAM_WE_N(weN0), .SRAM_UB_N(ub0), .SRAM_LB_N(lb0), .SRAM_CE_N(ce0), .SRAM_OE_N(oe0)
    );

    sram_controller #(.WAIT_CYCLES(3), .ADDR_BASE(BASE)) dut1 (
        .clk(clk), .rst(rst), .rd_en(rd1), .wr_en(wr1), .address(address), .write_data(writeData),
        .read_data(readData1), .ready(ready1), .addr_err(addrErr1), .SRAM_DQ(dq1), .SRAM_ADDR(sramAddr1),
        .SRAM_WE_N(weN1), .SRAM_UB_N(ub1), .SRAM_LB_N(lb1), .SRAM_CE_N(ce1), .SRAM_OE_N(oe1)
    );

    // Asynchronous SRAMs with OE tied active: they drive the bus whenever WE is high.
    logic [15:0] mem0 [0:262143];
    logic [15:0] mem1 [0:262143];

    assign dq0 = weN0 ? mem0[sramAddr0] : 16'bz;
    assign dq1 = weN1 ? mem1[sramAddr1] : 16'bz;

    always @(posedge clk) begin
        if (!weN0) mem0[sramAddr0] <= dq0;
        if (!weN1) mem1[sramAddr1] <= dq1;
    end

    logic [31:0] obsReadData;
    logic        obsReady, obsAddrErr, obsWeN;
    logic [15:0] obsDq;
    logic [17:0] obsAddr;

    assign obsReadData = (sel == 1) ? readData1 : readData0;
    assign obsReady    = (sel == 1) ? ready1    : ready0;
    assign obsAddrErr  = (sel == 1) ? addrErr1  : addrErr0;
    assign obsWeN      = (sel == 1) ? weN1      : weN0;
    assign obsDq       = (sel == 1) ? dq1       : dq0;
    assign obsAddr     = (sel == 1) ? sramAddr1 : sramAddr0;

    // Word-level reference: one 32-bit word per index, plus the last completed read per instance.
    logic [31:0] refMem   [2][128];
    logic [31:0] refRead  [2];
    logic [17:0] lastAddr [2];

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s (dut%0d): got %h, expected %h", tag, sel, actual, expected);
        end
    endtask

    function automatic bit isOutOfRange(input logic [31:0] addr);
        logic [31:0] off;
        off = addr - BASE;
`ifdef SRAM_ADDR_CHECK_EN
        return (addr < BASE) || ((off >> 19) != 32'd0);
`else
        return (off == 32'hFFFF_FFFF) && 1'b0;
`endif
    endfunction

    // Called just after a rising edge; that cycle is cycle 0 of the access.
    task automatic applyStimulus(input int s, input bit doRead, input bit doWrite, input logic [31:0] addr,
                                 input logic [31:0] data, input bit keep, input bit dropEarly);
        int          w;
        int          doneCycle;
        bit          oor;
        bit          isWrite;
        bit          half;
        logic [31:0] off;
        logic [16:0] word;
        sel       = s;
        rdEn      = doRead;
        wrEn      = doWrite;
        address   = addr;
        writeData = data;
        w         = (s == 1) ? 3 : 1;
        off       = addr - BASE;
        word      = off[18:2];
        oor       = isOutOfRange(addr);
        isWrite   = doWrite;
        doneCycle = oor ? 1 : 2 * w + 1;
        if (!isWrite) refRead[s] = oor ? 32'd0 : refMem[s][word[6:0]];
        else if (!oor) refMem[s][word[6:0]] = data;
        for (int k = 0; k <= doneCycle; k++) begin
            @(negedge clk);
            checkOutput("ready", 32'(obsReady), 32'(k == doneCycle));
            if (k >= 1 && k < doneCycle) begin
                half = (k > w);
                checkOutput("sramAddr", 32'(obsAddr), 32'({word, half}));
                checkOutput("weN", 32'(obsWeN), 32'(!isWrite));
                if (isWrite) checkOutput("dqWrite", 32'(obsDq), 32'(half ? data[31:16] : data[15:0]));
            end
            if (k == doneCycle) begin
                checkOutput("readData", obsReadData, refRead[s]);
                checkOutput("addrErr", 32'(obsAddrErr), 32'(oor));
                checkOutput("weNDone", 32'(obsWeN), 32'd1);
            end
            @(posedge clk);
            #1;
            if (k == 0 && dropEarly) begin
                rdEn = 1'b0;
                wrEn = 1'b0;
            end
        end
        if (!oor) lastAddr[s] = {word, 1'b1};
        if (!keep) begin
            rdEn = 1'b0;
            wrEn = 1'b0;
            @(negedge clk);
            checkOutput("idleReady", 32'(obsReady), 32'd1);
            checkOutput("idleWeN", 32'(obsWeN), 32'd1);
            checkOutput("idleAddrHold", 32'(obsAddr), 32'(lastAddr[s]));
            checkOutput("idleDqReleased", 32'(obsDq), 32'((s == 1) ? mem1[lastAddr[s]] : mem0[lastAddr[s]]));
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int op;
        int s;
        for (int i = 0; i < 262144; i++) begin
            mem0[i] = 16'd0;
            mem1[i] = 16'd0;
        end
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 128; j++) refMem[i][j] = 32'd0;
            refRead[i]  = 32'd0;
            lastAddr[i] = 18'd0;
        end

        #1 rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            sel = i;
            @(negedge clk);
            checkOutput("rstReady", 32'(obsReady), 32'd1);
            checkOutput("rstReadData", obsReadData, 32'd0);
            checkOutput("rstSramAddr", 32'(obsAddr), 32'd0);
            checkOutput("rstWeN", 32'(obsWeN), 32'd1);
            checkOutput("rstAddrErr", 32'(obsAddrErr), 32'd0);
        end
        checkOutput("tiedStrobes", 32'({ub0, lb0, ce0, oe0, ub1, lb1, ce1, oe1}), 32'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] write then read, W=1");
        applyStimulus(0, 1'b0, 1'b1, BASE, 32'hDEADBEEF, 1'b0, 1'b0);
        applyStimulus(0, 1'b1, 1'b0, BASE, 32'd0, 1'b0, 1'b0);

        $display("[TB] reset in the middle of a write");
        sel = 0;
        wrEn = 1'b1;
        address = BASE + 32'd400;
        writeData = 32'hCAFEF00D;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        wrEn = 1'b0;
        @(negedge clk);
        checkOutput("midRstWeN", 32'(obsWeN), 32'd1);
        checkOutput("midRstDqReleased", 32'(obsDq), 32'(mem0[0]));
        checkOutput("midRstReadData", obsReadData, 32'd0);
        checkOutput("midRstReady", 32'(obsReady), 32'd1);
        checkOutput("midRstSramAddr", 32'(obsAddr), 32'd0);
        checkOutput("lowHalfKept", 32'(mem0[200]), 32'h0000F00D);
        checkOutput("highHalfUnwritten", 32'(mem0[201]), 32'd0);
        refRead[0]  = 32'd0;
        lastAddr[0] = 18'd0;
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] wait states, W=3");
        applyStimulus(1, 1'b0, 1'b1, BASE + 32'd8, 32'h0BADF00D, 1'b0, 1'b0);
        applyStimulus(1, 1'b1, 1'b0, BASE + 32'd8, 32'd0, 1'b0, 1'b0);

        $display("[TB] simultaneous requests");
        applyStimulus(0, 1'b1, 1'b0, BASE, 32'd0, 1'b0, 1'b0);
        applyStimulus(0, 1'b1, 1'b1, BASE, 32'h12345678, 1'b0, 1'b0);

        $display("[TB] back-to-back reads");
        applyStimulus(0, 1'b0, 1'b1, BASE + 32'd4, 32'hA5A55A5A, 1'b0, 1'b0);
        applyStimulus(0, 1'b1, 1'b0, BASE, 32'd0, 1'b1, 1'b0);
        applyStimulus(0, 1'b1, 1'b0, BASE + 32'd4, 32'd0, 1'b0, 1'b0);

`ifdef SRAM_ADDR_CHECK_EN
        $display("[TB] out-of-range accesses");
        applyStimulus(0, 1'b1, 1'b0, 32'd16, 32'd0, 1'b0, 1'b0);
        applyStimulus(1, 1'b0, 1'b1, BASE + 32'h0008_0000, 32'h11112222, 1'b0, 1'b0);
`endif

        $display("[TB] randomized accesses");
        for (int i = 0; i < 80; i++) begin
            s  = int'($urandom_range(0, 1));
            op = int'($urandom_range(0, 2));
`ifdef SRAM_ADDR_CHECK_EN
            if ($urandom_range(0, 9) == 0) begin
                applyStimulus(s, 1'b1, 1'b0, BASE - 32'd4 * ($urandom_range(1, 8)), 32'd0, 1'b0, 1'b0);
                continue;
            end
`endif
            applyStimulus(s, op != 1, op != 0, BASE + 32'd4 * $urandom_range(0, 63), $urandom,
                          $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1);
        end
        rdEn = 1'b0;
        wrEn = 1'b0;
        @(posedge clk);
        #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
